// File: rtl/myfilter_pkg.sv
// Shared types and widths for the myfilter datapath and its control sequencer.
package myfilter_pkg;

    localparam int DATABITS = 16;
    localparam int ACCBITS  = 40;

    typedef enum logic [2:0] {
        ALU_NOP  = 3'd0,
        ALU_MU   = 3'd1,
        ALU_ADMU = 3'd2,
        ALU_SATA = 3'd3
    } alu_cmd_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MAC   = 3'd1,
        SAT   = 3'd2,
        HOLD  = 3'd3,
        CLEAR = 3'd4
    } seq_state_t;

endpackage

// File: rtl/fir_sequencer_svamod.sv
// Simulation-only companion checks for fir_sequencer: no X on outputs once out of reset,
// plus result handshake and load-to-valid properties.
`ifndef SYNTHESIS
module fir_sequencer_svamod
    import myfilter_pkg::*;
#(
    parameter int ADDRBITS = 3
) (
    input logic                clk,
    input logic                rst_n,
    input logic                sample_valid_in,
    input logic                sample_ready_out,
    input logic                smem_we_out,
    input logic [ADDRBITS-1:0] smem_addr_out,
    input logic [ADDRBITS-1:0] cmem_addr_out,
    input alu_cmd_t            cmd_out,
    input logic                acc_load_out,
    input logic                out_load_out,
    input logic                result_valid_out,
    input logic                result_ready_in,
    input logic                busy_out
);

    assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown({sample_ready_out, smem_we_out, smem_addr_out, cmem_addr_out,
                     cmd_out, acc_load_out, out_load_out, result_valid_out, busy_out}));

    assert property (@(posedge clk) disable iff (!rst_n)
        (sample_valid_in && sample_ready_out) |-> smem_we_out);

    assert property (@(posedge clk) disable iff (!rst_n)
        result_valid_out |-> (!sample_ready_out && busy_out));

    assert property (@(posedge clk) disable iff (!rst_n)
        out_load_out |=> result_valid_out);

    assert property (@(posedge clk) disable iff (!rst_n)
        (result_valid_out && !result_ready_in) |=> result_valid_out);

    assert property (@(posedge clk) disable iff (!rst_n)
        (cmd_out == ALU_SATA) |-> out_load_out);

endmodule
`endif

// File: rtl/fir_sequencer.sv
// Control FSM sequencing the shared filter ALU for one FIR output per accepted sample.
// Optional buffer-clear sequence is enabled with the FIR_CLEAR_EN macro.
module fir_sequencer
    import myfilter_pkg::*;
#(
    parameter int TAPS     = 8,
    parameter int ADDRBITS = $clog2(TAPS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_valid_in,
    output logic                sample_ready_out,
    output logic                smem_we_out,
    output logic [ADDRBITS-1:0] smem_addr_out,
    output logic [ADDRBITS-1:0] cmem_addr_out,
    output alu_cmd_t            cmd_out,
    output logic                acc_load_out,
    output logic                out_load_out,
`ifdef FIR_CLEAR_EN
    input  logic                clear_in,
    output logic                smem_zero_out,
`endif
    output logic                result_valid_out,
    input  logic                result_ready_in,
    output logic                busy_out
);

    localparam int                  KBITS     = $clog2(TAPS + 1);
    localparam logic [KBITS-1:0]    K_LAST    = KBITS'(TAPS);
    localparam logic [ADDRBITS-1:0] WPTR_LAST = ADDRBITS'(TAPS - 1);
`ifdef FIR_CLEAR_EN
    localparam logic [KBITS-1:0]    CLR_LAST  = KBITS'(TAPS - 1);
`endif

    seq_state_t          state_q, state_d;
    logic [ADDRBITS-1:0] wptr_q, wptr_d;
    logic [ADDRBITS-1:0] newest_q, newest_d;
    logic [KBITS-1:0]    k_q, k_d;
    logic [ADDRBITS-1:0] kAddr;
    logic [ADDRBITS-1:0] rdAddr;
    logic                clearReq;

    // Modulo-TAPS walk back from the newest sample; the wrap term folds in TAPS so
    // non-power-of-two buffers stay exact.
    assign kAddr  = k_q[ADDRBITS-1:0];
    assign rdAddr = (newest_q >= kAddr) ? (newest_q - kAddr)
                                        : (newest_q + ADDRBITS'(TAPS) - kAddr);

`ifdef FIR_CLEAR_EN
    assign clearReq = clear_in;
`else
    assign clearReq = 1'b0;
`endif

    assign busy_out = (state_q != IDLE);

    always_comb begin
        state_d          = state_q;
        wptr_d           = wptr_q;
        newest_d         = newest_q;
        k_d              = k_q;
        sample_ready_out = 1'b0;
        smem_we_out      = 1'b0;
        smem_addr_out    = '0;
        cmem_addr_out    = '0;
        cmd_out          = ALU_NOP;
        acc_load_out     = 1'b0;
        out_load_out     = 1'b0;
        result_valid_out = 1'b0;
`ifdef FIR_CLEAR_EN
        smem_zero_out    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                sample_ready_out = rst_n && !clearReq;
                if (clearReq) begin
                    state_d = CLEAR;
                    k_d     = '0;
                end else if (sample_ready_out && sample_valid_in) begin
                    smem_we_out   = 1'b1;
                    smem_addr_out = wptr_q;
                    newest_d      = wptr_q;
                    wptr_d        = (wptr_q == WPTR_LAST) ? '0 : wptr_q + ADDRBITS'(1);
                    k_d           = '0;
                    state_d       = MAC;
                end
            end
            // Commands lag their addresses by one cycle to cover the memory read latency.
            MAC: begin
                if (k_q != K_LAST) begin
                    cmem_addr_out = kAddr;
                    smem_addr_out = rdAddr;
                end
                if (k_q == KBITS'(1)) begin
                    cmd_out = ALU_MU;
                end else if (k_q != '0) begin
                    cmd_out = ALU_ADMU;
                end
                acc_load_out = (k_q != '0);
                if (k_q == K_LAST) begin
                    state_d = SAT;
                end else begin
                    k_d = k_q + KBITS'(1);
                end
            end
            SAT: begin
                cmd_out      = ALU_SATA;
                out_load_out = 1'b1;
                state_d      = HOLD;
            end
            HOLD: begin
                result_valid_out = 1'b1;
                if (result_ready_in) begin
                    state_d = IDLE;
                end
            end
`ifdef FIR_CLEAR_EN
            CLEAR: begin
                smem_we_out   = 1'b1;
                smem_zero_out = 1'b1;
                smem_addr_out = kAddr;
                if (k_q == CLR_LAST) begin
                    wptr_d  = '0;
                    state_d = IDLE;
                end else begin
                    k_d = k_q + KBITS'(1);
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wptr_q   <= '0;
            newest_q <= '0;
            k_q      <= '0;
        end else begin
            state_q  <= state_d;
            wptr_q   <= wptr_d;
            newest_q <= newest_d;
            k_q      <= k_d;
        end
    end

`ifndef SYNTHESIS
    fir_sequencer_svamod #(.ADDRBITS(ADDRBITS)) svaCheck (
        .clk              (clk),
        .rst_n            (rst_n),
        .sample_valid_in  (sample_valid_in),
        .sample_ready_out (sample_ready_out),
        .smem_we_out      (smem_we_out),
        .smem_addr_out    (smem_addr_out),
        .cmem_addr_out    (cmem_addr_out),
        .cmd_out          (cmd_out),
        .acc_load_out     (acc_load_out),
        .out_load_out     (out_load_out),
        .result_valid_out (result_valid_out),
        .result_ready_in  (result_ready_in),
        .busy_out         (busy_out)
    );
`endif

endmodule

// File: tb/tb_fir_sequencer.sv
// Self-checking bench for fir_sequencer (TAPS=8): a per-transaction timeline model checks
// every output each cycle, with directed scenarios and literal pins plus a random run.
`timescale 1ns/1ps
module tb_fir_sequencer;
    import myfilter_pkg::*;

    localparam int TAPS     = 8;
    localparam int ADDRBITS = 3;
    localparam int HOLDPH   = TAPS + 3;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                sample_valid_in;
    logic                sample_ready_out;
    logic                smem_we_out;
    logic [ADDRBITS-1:0] smem_addr_out;
    logic [ADDRBITS-1:0] cmem_addr_out;
    alu_cmd_t            cmd_out;
    logic                acc_load_out;
    logic                out_load_out;
    logic                result_valid_out;
    logic                result_ready_in;
    logic                busy_out;
`ifdef FIR_CLEAR_EN
    logic                clear_in;
    logic                smem_zero_out;
`endif

    always #5 clk = ~clk;

    fir_sequencer #(.TAPS(TAPS), .ADDRBITS(ADDRBITS)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .sample_valid_in  (sample_valid_in),
        .sample_ready_out (sample_ready_out),
        .smem_we_out      (smem_we_out),
        .smem_addr_out    (smem_addr_out),
        .cmem_addr_out    (cmem_addr_out),
        .cmd_out          (cmd_out),
        .acc_load_out     (acc_load_out),
        .out_load_out     (out_load_out),
`ifdef FIR_CLEAR_EN
        .clear_in         (clear_in),
        .smem_zero_out    (smem_zero_out),
`endif
        .result_valid_out (result_valid_out),
        .result_ready_in  (result_ready_in),
        .busy_out         (busy_out)
    );

    int checks = 0;
    int errors = 0;
    int cycleCount = 0;

    // Model state: phase is cycles since the accepting cycle (0 = idle), clearIdx >= 0 while clearing.
    int phase = 0;
    int clearIdx = -1;
    int mWptr = 0;
    int mNewest = 0;
    int acceptCycle = 0;
    logic prevValid = 1'b0;
    int writeLog[$];
    int readLog[$];
    int latLog[$];

    int readsAt3[TAPS] = '{3, 2, 1, 0, 7, 6, 5, 4};
    int readsAt0[TAPS] = '{0, 7, 6, 5, 4, 3, 2, 1};

    int expCmd, expReady, expWe, expAcc, expOut, expValid, expBusy, expZero, expSmem, expCmem;
    bit chkSmem, chkCmem, clr;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cycleCount, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        cycleCount++;
        expCmd = int'(ALU_NOP); expReady = 0; expWe = 0; expAcc = 0; expOut = 0;
        expValid = 0; expBusy = 0; expZero = 0; expSmem = 0; expCmem = 0;
        chkSmem = 1'b1; chkCmem = 1'b1;
        clr = 1'b0;
`ifdef FIR_CLEAR_EN
        clr = clear_in;
`endif
        if (!rst_n) begin
            // all defaults: reset outputs
        end else if (clearIdx >= 0) begin
            expBusy = 1; expWe = 1; expZero = 1; expSmem = clearIdx;
        end else if (phase == 0) begin
            expReady = clr ? 0 : 1;
            expWe    = (sample_valid_in && !clr) ? 1 : 0;
            chkSmem  = (expWe == 1);
            expSmem  = mWptr;
        end else if (phase <= TAPS + 1) begin
            expBusy = 1;
            expCmd  = (phase == 1) ? int'(ALU_NOP) : (phase == 2) ? int'(ALU_MU) : int'(ALU_ADMU);
            expAcc  = (phase >= 2) ? 1 : 0;
            if (phase - 1 < TAPS) begin
                expSmem = (mNewest - (phase - 1) + TAPS) % TAPS;
                expCmem = phase - 1;
            end
        end else if (phase == TAPS + 2) begin
            expBusy = 1; expCmd = int'(ALU_SATA); expOut = 1;
            chkSmem = 1'b0; chkCmem = 1'b0;
        end else begin
            expBusy = 1; expValid = 1;
            chkSmem = 1'b0; chkCmem = 1'b0;
        end

        checkOutput("cmd_out", int'(cmd_out), expCmd);
        checkOutput("sample_ready_out", int'(sample_ready_out), expReady);
        checkOutput("smem_we_out", int'(smem_we_out), expWe);
        checkOutput("acc_load_out", int'(acc_load_out), expAcc);
        checkOutput("out_load_out", int'(out_load_out), expOut);
        checkOutput("result_valid_out", int'(result_valid_out), expValid);
        checkOutput("busy_out", int'(busy_out), expBusy);
        if (chkSmem) checkOutput("smem_addr_out", int'(smem_addr_out), expSmem);
        if (chkCmem) checkOutput("cmem_addr_out", int'(cmem_addr_out), expCmem);
`ifdef FIR_CLEAR_EN
        checkOutput("smem_zero_out", int'(smem_zero_out), expZero);
`endif

        if (rst_n && phase == 0 && clearIdx < 0 && sample_valid_in && !clr) begin
            writeLog.push_back(int'(smem_addr_out));
            acceptCycle = cycleCount;
        end
        if (rst_n && phase >= 1 && phase <= TAPS) readLog.push_back(int'(smem_addr_out));
        if (rst_n && result_valid_out && !prevValid) latLog.push_back(cycleCount - acceptCycle);
        prevValid = result_valid_out;

        if (!rst_n) begin
            phase = 0; clearIdx = -1; mWptr = 0;
        end else if (clearIdx >= 0) begin
            if (clearIdx == TAPS - 1) begin
                clearIdx = -1; mWptr = 0;
            end else begin
                clearIdx++;
            end
        end else if (phase == 0) begin
            if (clr) begin
                clearIdx = 0;
            end else if (sample_valid_in) begin
                mNewest = mWptr;
                mWptr = (mWptr + 1) % TAPS;
                phase = 1;
            end
        end else if (phase < HOLDPH) begin
            phase++;
        end else if (result_ready_in) begin
            phase = 0;
        end
    end

    // Drives inputs now (just after a rising edge) and holds them for n cycles.
    task automatic applyStimulus(input bit v, input bit r, input int n);
        sample_valid_in = v;
        result_ready_in = r;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 200; i++) begin
            if (phase == 0 && clearIdx < 0) return;
            @(posedge clk);
            #1;
        end
        checkOutput("waitIdle timeout", 0, 1);
    endtask

    task automatic waitPhase(input int p);
        for (int i = 0; i < 200; i++) begin
            if (phase >= p) return;
            @(posedge clk);
            #1;
        end
        checkOutput("waitPhase timeout", 0, 1);
    endtask

    int wBase, rBase, lBase;

    initial begin
        rst_n = 1'b0;
        sample_valid_in = 1'b0;
        result_ready_in = 1'b0;
`ifdef FIR_CLEAR_EN
        clear_in = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post-reset ready", int'(sample_ready_out), 1);
        checkOutput("post-reset cmd", int'(cmd_out), 0);
        checkOutput("post-reset valid", int'(result_valid_out), 0);
        checkOutput("post-reset busy", int'(busy_out), 0);
        @(posedge clk);
        #1;

        // Nine back-to-back samples: write pointer wraps after 8.
        wBase = writeLog.size(); rBase = readLog.size(); lBase = latLog.size();
        for (int s = 0; s < 9; s++) begin
            waitIdle();
            applyStimulus(1'b1, 1'b1, 1);
            applyStimulus(1'b0, 1'b1, 0);
        end
        waitIdle();
        checkOutput("nine write count", writeLog.size() - wBase, 9);
        checkOutput("nine read count", readLog.size() - rBase, 9 * TAPS);
        if (writeLog.size() - wBase >= 9)
            for (int s = 0; s < 9; s++) checkOutput("write addr", writeLog[wBase + s], s % TAPS);
        if (readLog.size() - rBase >= 9 * TAPS) begin
            for (int j = 0; j < TAPS; j++) checkOutput("reads wptr=3", readLog[rBase + 3 * TAPS + j], readsAt3[j]);
            for (int j = 0; j < TAPS; j++) checkOutput("reads 9th", readLog[rBase + 8 * TAPS + j], readsAt0[j]);
        end
        if (latLog.size() - lBase >= 4) checkOutput("latency", latLog[lBase + 3], 11);
        else checkOutput("latency count", latLog.size() - lBase, 9);

        // Consumer stalls in HOLD while a new sample is pending.
        applyStimulus(1'b1, 1'b0, 0);
        waitPhase(HOLDPH);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall valid", int'(result_valid_out), 1);
            checkOutput("stall we", int'(smem_we_out), 0);
            checkOutput("stall ready", int'(sample_ready_out), 0);
            @(posedge clk);
            #1;
        end
        applyStimulus(1'b1, 1'b1, 2);
        applyStimulus(1'b0, 1'b1, 0);
        waitIdle();
        checkOutput("stall sample addr", writeLog[writeLog.size() - 2], 1);
        checkOutput("after-stall addr", writeLog[writeLog.size() - 1], 2);

        // Asynchronous reset in the middle of accumulation.
        applyStimulus(1'b1, 1'b1, 1);
        applyStimulus(1'b0, 1'b1, 0);
        waitPhase(5);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset cmd", int'(cmd_out), 0);
        checkOutput("midreset busy", int'(busy_out), 0);
        checkOutput("midreset acc", int'(acc_load_out), 0);
        checkOutput("midreset out", int'(out_load_out), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        waitIdle();
        applyStimulus(1'b1, 1'b1, 1);
        applyStimulus(1'b0, 1'b1, 0);
        waitIdle();
        checkOutput("post-midreset addr", writeLog[writeLog.size() - 1], 0);

`ifdef FIR_CLEAR_EN
        // Clear wins over a simultaneous sample; the sample lands at address 0 afterwards.
        clear_in = 1'b1;
        applyStimulus(1'b1, 1'b1, 1);
        clear_in = 1'b0;
        waitIdle();
        applyStimulus(1'b1, 1'b1, 1);
        applyStimulus(1'b0, 1'b1, 0);
        waitIdle();
        checkOutput("post-clear addr", writeLog[writeLog.size() - 1], 0);
`endif

        for (int i = 0; i < 800; i++) begin
`ifdef FIR_CLEAR_EN
            clear_in = ($urandom_range(0, 19) == 0);
`endif
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1);
        end
`ifdef FIR_CLEAR_EN
        clear_in = 1'b0;
`endif
        applyStimulus(1'b0, 1'b1, 0);
        waitIdle();
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
